// File: rtl/user_port_loader.sv
// Host-side block loader/dumper driving the core's user data-memory port.
// Define LOADER_CHECKSUM_EN to add the running `checksum` output.
module user_port_loader #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] user_addr,
  output logic              user_we,
  output logic [DATA_W-1:0] user_din,
  input  logic [DATA_W-1:0] user_dout,
  output logic              busy,
`ifdef LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StLoad, StDump, StDrain, StDone} state_e;

  localparam logic [ADDR_W:0]   MaxLen  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LenOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remain_q;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_q [3];
  logic [1:0]        wr_ptr_q, rd_ptr_q, count_q;

  logic              accept, wr_hs, rd_hs, issue;
  logic [ADDR_W:0]   len_clamped;
  logic [2:0]        occupancy;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign accept      = cmd_valid && (state_q == StIdle);
  assign len_clamped = (cmd_len > MaxLen) ? MaxLen : cmd_len;
  assign wr_hs       = (state_q == StLoad) && wr_valid;
  assign rd_hs       = rd_valid && rd_ready;
  // Reads in flight count against FIFO space so a stalled consumer never overflows it.
  assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q};
  assign issue       = (state_q == StDump) && (remain_q != '0) && (occupancy < 3'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          // Zero-length commands pass through an empty DRAIN so done lands in C+2.
          if (len_clamped == '0) state_d = StDrain;
          else if (cmd_dir)      state_d = StDump;
          else                   state_d = StLoad;
        end
      end
      StLoad:  if (wr_hs && remain_q == LenOne) state_d = StDone;
      StDump:  if (issue && remain_q == LenOne) state_d = StDrain;
      StDrain: begin
        if (!inflight_q && (count_q == 2'd0 || (count_q == 2'd1 && rd_hs))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    wr_ready  = (state_q == StLoad);
    user_we   = wr_ready && wr_valid;
    user_din  = wr_ready ? wr_data : '0;
    user_addr = (state_q == StLoad || state_q == StDump) ? addr_q : '0;
    rd_valid  = (state_q == StDump || state_q == StDrain) && (count_q != 2'd0);
    rd_data   = rd_valid ? fifo_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      remain_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= issue;
      if (accept) begin
        addr_q   <= cmd_base;
        remain_q <= len_clamped;
        wr_ptr_q <= 2'd0;
        rd_ptr_q <= 2'd0;
        count_q  <= 2'd0;
      end else begin
        if (wr_hs || issue) begin
          addr_q   <= addr_q + AddrOne;
          remain_q <= remain_q - LenOne;
        end
        if (inflight_q) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (rd_hs)      rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (inflight_q && !rd_hs)      count_q <= count_q + 2'd1;
        else if (!inflight_q && rd_hs) count_q <= count_q - 2'd1;
      end
    end
  end

  // user_dout is valid the cycle after the address was issued.
  always_ff @(posedge clk) begin
    if (inflight_q) fifo_q[wr_ptr_q] <= user_dout;
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (wr_hs) begin
      checksum_q <= checksum_q + wr_data;
    end else if (rd_hs) begin
      checksum_q <= checksum_q + rd_data;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
